// File: rtl/signed_seq_calculator.sv
// Sign-magnitude calculator with start/done handshake.
// Add/sub in one cycle, shift-add multiply and restoring divide in N cycles.
module signed_seq_calculator #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic           signA,
    input  logic [N-1:0]   B,
    input  logic           signB,
    input  logic [1:0]     sel,
    output logic [2*N:0]   O,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int W  = 2 * N + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            accept;

    logic [N-1:0]    a_reg, b_reg, b_sh;
    logic            neg;
    logic [2*N-1:0]  prod, addend, prod_nx;
    logic [N-1:0]    rem, dvd, rem_nx, dvd_nx;
    logic [N:0]      rem_sh;
    logic [N+1:0]    diff;
    logic            ge;

    logic [N+1:0]    va, vb, sum;
    logic [W-1:0]    add_res;
    logic [2*N-1:0]  mag_fin;
    logic [W-1:0]    ext_fin, res_fin;
    logic            err_fin;

    assign accept = start && (state == IDLE);
    assign last   = (cnt == CW'(N - 1));

    // State register, cleared asynchronously so an abort is immediate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: add/sub skip straight to FIN, mul/div iterate N cycles
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = sel[1] ? (sel[0] ? DIV : MUL) : FIN;
            MUL:  if (last) state_nx = FIN;
            DIV:  if (last) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == FIN);
    end

    // Add/sub straight from the inputs; negative zero collapses to zero
    always_comb begin
        va      = signA ? -{2'b00, A} : {2'b00, A};
        vb      = signB ? -{2'b00, B} : {2'b00, B};
        sum     = sel[0] ? (va - vb) : (va + vb);
        add_res = {{(N-1){sum[N+1]}}, sum};
    end

    // One shift-add step and one restoring-divide step per cycle
    always_comb begin
        addend  = b_sh[0] ? ({{N{1'b0}}, a_reg} << cnt) : '0;
        prod_nx = prod + addend;
        rem_sh  = {rem, dvd[N-1]};
        diff    = {1'b0, rem_sh} - {2'b00, b_reg};
        ge      = ~diff[N+1];
        rem_nx  = ge ? diff[N-1:0] : rem_sh[N-1:0];
        dvd_nx  = {dvd[N-2:0], ge};
    end

    // Final signed result; zero magnitudes never come out negative
    always_comb begin
        mag_fin = (state == MUL) ? prod_nx : {{N{1'b0}}, dvd_nx};
        ext_fin = {1'b0, mag_fin};
        res_fin = (neg && (|mag_fin)) ? -ext_fin : ext_fin;
        err_fin = (state == DIV) && (b_reg == '0);
    end

    // Operand capture, iteration state and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            b_sh  <= '0;
            neg   <= 1'b0;
            prod  <= '0;
            rem   <= '0;
            dvd   <= '0;
            cnt   <= '0;
            O     <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            b_sh  <= B;
            neg   <= signA ^ signB;
            prod  <= '0;
            rem   <= '0;
            dvd   <= A;
            cnt   <= '0;
            if (!sel[1]) begin
                O   <= add_res;
                err <= 1'b0;
            end
        end else if (state == MUL || state == DIV) begin
            cnt <= cnt + CW'(1);
            if (state == MUL) begin
                prod <= prod_nx;
                b_sh <= b_sh >> 1;
            end else begin
                rem <= rem_nx;
                dvd <= dvd_nx;
            end
            if (last) begin
                O   <= err_fin ? '0 : res_fin;
                err <= err_fin;
            end
        end
    end

endmodule

// File: tb/tb_signed_seq_calculator.sv
// Directed bench for signed_seq_calculator at N=4.
// Expected results are hand-computed two's-complement values.
module tb_signed_seq_calculator;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A = '0;
    logic         signA = 1'b0;
    logic [N-1:0] B = '0;
    logic         signB = 1'b0;
    logic [1:0]   sel = 2'b00;
    logic [2*N:0] O;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int failures = 0;

    signed_seq_calculator #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .signA (signA),
        .B     (B),
        .signB (signB),
        .sel   (sel),
        .O     (O),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] a, input logic sa,
                         input logic [N-1:0] b, input logic sb,
                         input logic [1:0] s);
        A = a; signA = sa; B = b; signB = sb; sel = s;
    endtask

    // Wait for done from cycle "lat"; returns the cycle it was seen in
    task automatic wait_done(inout int lat);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [N-1:0] a, input logic sa,
                          input logic [N-1:0] b, input logic sb,
                          input logic [1:0] s,
                          input logic [2*N:0] exp_o, input logic exp_err,
                          input int exp_lat);
        int lat;
        drive(a, sa, b, sb, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive('0, 1'b0, '0, 1'b0, 2'b00);
        lat = 1;
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_O"}, 32'(O), 32'(exp_o));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, 32'(O), 32'(exp_o));
    endtask

    initial begin
        int lat;
        int ndone;

        #2;
        chk("rst_out", {O, busy, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add",     4'd7,  1'b0, 4'd3,  1'b1, 2'b00, 9'h004, 1'b0, 1);
        run_op("sub",     4'd5,  1'b1, 4'd9,  1'b0, 2'b01, 9'h1F2, 1'b0, 1);
        run_op("addmin",  4'd15, 1'b1, 4'd15, 1'b1, 2'b00, 9'h1E2, 1'b0, 1);
        run_op("subnz",   4'd0,  1'b1, 4'd0,  1'b1, 2'b01, 9'h000, 1'b0, 1);
        run_op("mulneg",  4'd15, 1'b1, 4'd15, 1'b0, 2'b10, 9'h11F, 1'b0, 5);
        run_op("mulpos",  4'd15, 1'b1, 4'd15, 1'b1, 2'b10, 9'h0E1, 1'b0, 5);
        run_op("mulzero", 4'd0,  1'b1, 4'd5,  1'b0, 2'b10, 9'h000, 1'b0, 5);
        run_op("mulmix",  4'd6,  1'b0, 4'd5,  1'b1, 2'b10, 9'h1E2, 1'b0, 5);
        run_op("div",     4'd13, 1'b1, 4'd4,  1'b0, 2'b11, 9'h1FD, 1'b0, 5);
        run_op("divq0",   4'd3,  1'b1, 4'd7,  1'b0, 2'b11, 9'h000, 1'b0, 5);
        run_op("divmax",  4'd15, 1'b0, 4'd1,  1'b0, 2'b11, 9'h00F, 1'b0, 5);
        run_op("divz",    4'd9,  1'b0, 4'd0,  1'b0, 2'b11, 9'h000, 1'b1, 5);
        run_op("addclr",  4'd2,  1'b0, 4'd2,  1'b0, 2'b00, 9'h004, 1'b0, 1);

        // Start pulse during a multiply must be dropped
        drive(4'd15, 1'b1, 4'd15, 1'b0, 2'b10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        drive(4'd1, 1'b0, 4'd1, 1'b0, 2'b00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        wait_done(lat);
        chk("ign_lat", 32'(lat), 32'd5);
        chk("ign_O", 32'(O), 32'h11F);
        @(posedge clk); #1;
        chk("ign_idle", {30'd0, busy, done}, 32'd0);

        // Reset in the middle of a multiply
        drive(4'd7, 1'b0, 4'd3, 1'b0, 2'b10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_out", {O, busy, done, err}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("arst_nodone", 32'(ndone), 32'd0);
        run_op("postrst", 4'd4, 1'b1, 4'd1, 1'b1, 2'b01, 9'h1FD, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_seq_calculator.md
# signed_seq_calculator

Parametrised signed calculator that accepts two N-bit sign-magnitude operands with a start/done handshake and returns a (2N+1)-bit two's-complement result. It replaces the 4-bit combinational calculator: width is generic, operations are registered, and it adds iterative multiply and divide with a divide-by-zero flag. It sits between operand-entry logic (switches/keypad) and the display/formatting stage.

## Interface
- `N`, default 4: operand magnitude width in bits. Legal range N >= 2.
- `clk`  input  1  system clock. All state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  request strobe. Sampled only when `busy`=0.
- `A`  input  N  magnitude of operand A.
- `signA`  input  1  sign of operand A (1 = negative).
- `B`  input  N  magnitude of operand B.
- `signB`  input  1  sign of operand B.
- `sel`  input  2  operation: 00 add, 01 subtract (A-B), 10 multiply, 11 divide (A/B).
- `O`  output  2N+1  two's-complement result, held until the next `done`.
- `busy`  output  1  operation in progress; `start` is ignored while high.
- `done`  output  1  single-cycle pulse; `O` and `err` are valid in this cycle.
- `err`  output  1  divide-by-zero flag, updated with `done`.

## Operation
- Capture: with `start`=1 and `busy`=0, register A, B, signA, signB and sel at the clock edge. Inputs may change freely afterwards.
- Conversion: each operand becomes a signed value of +mag or -mag. Magnitude 0 with sign 1 is treated as 0.
- States:
  - IDLE: leave on accepted start. sel 0x goes to FINISH; sel 10 goes to MUL; sel 11 goes to DIV.
  - MUL: shift-add on the magnitudes, one bit of B per cycle, N cycles, LSB first. Then go to FINISH.
  - DIV: restoring division on the magnitudes, one quotient bit per cycle, N cycles, MSB first. Then go to FINISH.
  - FINISH: drive the result, pulse `done`, return to IDLE.
- Result rules:
  - Add/sub: computed in N+2 bits and sign-extended to 2N+1 bits. Never overflows.
  - Multiply: the 2N-bit magnitude product, negated if signA XOR signB and the product is nonzero. Fits in 2N+1 bits for every input.
  - Divide: quotient truncated toward zero, sign = signA XOR signB. A zero quotient is always +0. Remainder is discarded.
  - Divide with B magnitude = 0: `O`=0 and `err`=1. Still takes the full N-cycle DIV path, so latency does not depend on data.
  - `err` is 0 for every other completed operation.
- `busy` is high in MUL, DIV and FINISH, and low in IDLE.

## Timing
- Latency is counted from the accepting edge (cycle 0):
  - add/sub: `done` high in cycle 1.
  - mul/div: `done` high in cycle N+1.
- `done` is high for exactly one cycle, in FINISH. `O` and `err` update at the same edge that raises `done`, and stay stable until the next `done`.
- `start` asserted while `busy`=1, including the `done` cycle, is ignored and is not queued.
- Back-to-back: the earliest next accepted start is the cycle after `done`.
- Reset, at any time including mid-MUL/DIV:
  - State goes to IDLE immediately, asynchronously.
  - `O`=0, `busy`=0, `done`=0, `err`=0; the internal iteration counter and accumulators are cleared.
  - No `done` is produced for an aborted operation.
- The first start is accepted at the first rising edge after `rst` is deasserted.

## Test plan
- Add, N=4: A=7 signA=0, B=3 signB=1, sel=00. Required: `done` in cycle 1, O=+4 (9'h004), err=0.
- Subtract, N=4: A=5 signA=1, B=9 signB=0, sel=01. Required: O=-14 (9'h1F2), latency 1.
- Multiply extremes, N=4: A=15 signA=1, B=15 signB=0, sel=10. Required: `busy` high cycles 1-5, `done` in cycle 5, O=-225 (9'h11F). Then repeat with signB=1. Required: O=+225 (9'h0E1).
- Divide, N=4: A=13 signA=1, B=4 signB=0, sel=11. Required: O=-3 (9'h1FD), err=0. Then A=3, B=7, signA=1. Required: O=0 (not negative zero).
- Divide by zero, N=4: A=9, B=0, sel=11. Required: `done` in cycle 5, O=0, err=1. The next add must clear err to 0.
- Control, N=4:
  - start a multiply, then pulse `start` with new operands in cycle 2: the pulse is ignored and the original result is returned.
  - start a multiply, then assert `rst` in cycle 3: all outputs are 0 immediately, no `done` follows, and a fresh add after reset completes in 1 cycle.
